// File: rtl/ltl_monitor_pkg.sv
// Shared types for the runtime-verification monitor's report path:
// the default report entry layout and the collector FSM states.
package ltl_monitor_pkg;

    localparam int NUM_REPORTS_DEF = 4;
    localparam int SYM_WIDTH_DEF   = 8;
    localparam int TS_WIDTH_DEF    = 32;

    typedef struct packed {
        logic [NUM_REPORTS_DEF-1:0] report;
        logic [SYM_WIDTH_DEF-1:0]   symbol;
        logic [TS_WIDTH_DEF-1:0]    timestamp;
    } report_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FULL  = 2'd2
    } collector_state_t;

endpackage

// File: rtl/ltl_report_collector_if.sv
// Report output channel. Handshake: a head entry transfers on every rising
// clk edge where out_valid && out_ready; payload is held stable while out_valid && !out_ready.
interface ltl_report_collector_if #(
    parameter int NUM_REPORTS = 4,
    parameter int SYM_WIDTH   = 8,
    parameter int TS_WIDTH    = 32
);
    logic                   out_valid;
    logic                   out_ready;
    logic [NUM_REPORTS-1:0] out_report;
    logic [SYM_WIDTH-1:0]   out_symbol;
    logic [TS_WIDTH-1:0]    out_timestamp;

    modport master (
        output out_valid, out_report, out_symbol, out_timestamp,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_report, out_symbol, out_timestamp,
        output out_ready
    );
endinterface

// File: rtl/ltl_report_fifo.sv
// Synchronous FIFO of report entries with occupancy count and a synchronous flush.
// The caller only pushes when there is room (or a pop in the same cycle).
module ltl_report_fifo
    import ltl_monitor_pkg::*;
#(
    parameter type entry_t = report_entry_t,
    parameter int  DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    entry_t        mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage is not reset; the collector masks the head while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= push_data;
    end

    assign head  = mem_q[rd_q];
    assign level = cnt_q;
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
endmodule

// File: rtl/ltl_report_collector.sv
// Pairs each non-zero automaton report vector with the symbol and timestamp that
// produced it, queues the entry, and tracks sticky overflow and drop counts.
module ltl_report_collector
    import ltl_monitor_pkg::*;
#(
    parameter int NUM_REPORTS = 4,
    parameter int SYM_WIDTH   = 8,
    parameter int TS_WIDTH    = 32,
    parameter int DEPTH       = 8,
    parameter int DROP_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic [SYM_WIDTH-1:0]   symbols,
    input  logic [NUM_REPORTS-1:0] report_i,
    input  logic                   clear,
    ltl_report_collector_if.master out_if,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_WIDTH-1:0]  drop_count,
    output collector_state_t       fsm_state
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [NUM_REPORTS-1:0] report;
        logic [SYM_WIDTH-1:0]   symbol;
        logic [TS_WIDTH-1:0]    timestamp;
    } entry_t;

    logic [TS_WIDTH-1:0]   ts_q;
    logic [TS_WIDTH-1:0]   pts_q;
    logic [SYM_WIDTH-1:0]  sym_q;
    logic                  pend_q;
    logic                  overflow_q;
    logic [DROP_WIDTH-1:0] drop_q;
    collector_state_t      state_q;
    logic                  valid_q;

    entry_t        push_entry, head;
    logic          fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    logic          req, deq, push, pop, drop;

    // report_i belongs to the symbol captured on the previous run cycle.
    assign req  = pend_q && (report_i != '0);
    assign deq  = valid_q && out_if.out_ready;
    assign push = req && !clear && (!fifo_full || deq);
    assign drop = req && !clear && fifo_full && !deq;
    assign pop  = deq && !clear && !fifo_empty;

    assign push_entry = '{report: report_i, symbol: sym_q, timestamp: pts_q};

    ltl_report_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (clear),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q   <= '0;
            pts_q  <= '0;
            sym_q  <= '0;
            pend_q <= 1'b0;
        end else if (clear) begin
            ts_q   <= '0;
            pend_q <= 1'b0;
        end else if (run) begin
            ts_q   <= ts_q + 1'b1;
            pts_q  <= ts_q;
            sym_q  <= symbols;
            pend_q <= 1'b1;
        end else begin
            pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (clear) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
        end else if (clear) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    state_q <= HOLD;
                    valid_q <= 1'b1;
                end
                HOLD: begin
                    if (push && !pop && fifo_level == LW'(DEPTH - 1)) begin
                        state_q <= FULL;
                    end else if (pop && !push && fifo_level == LW'(1)) begin
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: if (pop && !push) state_q <= HOLD;
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Mask the unreset FIFO storage so every output reads 0 while empty.
    assign out_if.out_valid     = valid_q;
    assign out_if.out_report    = valid_q ? head.report    : '0;
    assign out_if.out_symbol    = valid_q ? head.symbol    : '0;
    assign out_if.out_timestamp = valid_q ? head.timestamp : '0;

    assign level      = fifo_level;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign fsm_state  = state_q;
endmodule
